// File: rtl/lcd_pkg.sv
// Shared LCD constants and the text-scheduler state encoding.
package lcd_pkg;

    localparam int LINE_LENGTH = 16;
    localparam int FREQ        = 50_000_000;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        DONE
    } sched_state_t;

    // Counter width for a count of n cycles, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcd_text_scheduler.sv
// Arbitrates two text requesters onto one LCD sender and resends the last text when idle too long.
// Latency: req in IDLE to send_text is 2 cycles; requesters hold req until their done pulse.
module lcd_text_scheduler #(
    parameter int LINE_LENGTH    = lcd_pkg::LINE_LENGTH,
    parameter int REFRESH_CYCLES = 5_000_000,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [1:0]               req,
    input  logic [8*LINE_LENGTH-1:0] req0_line1,
    input  logic [8*LINE_LENGTH-1:0] req0_line2,
    input  logic [8*LINE_LENGTH-1:0] req1_line1,
    input  logic [8*LINE_LENGTH-1:0] req1_line2,
    input  logic                     sending_done,
    output logic [1:0]               grant,
    output logic [1:0]               done,
    output logic                     timeout_err,
    output logic                     send_text,
    output logic [8*LINE_LENGTH-1:0] line1_out,
    output logic [8*LINE_LENGTH-1:0] line2_out
);

    import lcd_pkg::*;

    localparam int RW = cnt_width(REFRESH_CYCLES);
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    sched_state_t  state;
    logic          prio;        // requester favoured when both ask
    logic          text_valid;
    logic [RW-1:0] refresh_cnt;
    logic [TW-1:0] timeout_cnt;
    logic          win_idx;

    always_comb begin
        win_idx = prio;
        if (req == 2'b01) begin
            win_idx = 1'b0;
        end else if (req == 2'b10) begin
            win_idx = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            prio        <= 1'b0;
            text_valid  <= 1'b0;
            refresh_cnt <= '0;
            timeout_cnt <= '0;
            grant       <= 2'b00;
            done        <= 2'b00;
            timeout_err <= 1'b0;
            send_text   <= 1'b0;
            line1_out   <= '0;
            line2_out   <= '0;
        end else begin
            send_text   <= 1'b0;
            done        <= 2'b00;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (refresh_cnt != REFRESH_LAST) begin
                        refresh_cnt <= refresh_cnt + 1'b1;
                    end
                    if (req != 2'b00) begin
                        grant      <= win_idx ? 2'b10 : 2'b01;
                        line1_out  <= win_idx ? req1_line1 : req0_line1;
                        line2_out  <= win_idx ? req1_line2 : req0_line2;
                        text_valid <= 1'b1;
                        state      <= START;
                    end else if (text_valid && refresh_cnt == REFRESH_LAST) begin
                        // Refresh: resend the held text with no owner.
                        state <= START;
                    end
                end
                START: begin
                    send_text   <= 1'b1;
                    timeout_cnt <= '0;
                    state       <= BUSY;
                end
                BUSY: begin
                    if (sending_done) begin
                        state <= DONE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        grant       <= 2'b00;
                        state       <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done        <= grant;
                    grant       <= 2'b00;
                    refresh_cnt <= '0;
                    if (grant != 2'b00) begin
                        prio <= ~grant[1];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lcd_text_scheduler.md
LCD_TEXT_SCHEDULER -- requirements
Module: lcd_text_scheduler

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 16, characters per LCD line.
REQ-002 SHALL have parameter REFRESH_CYCLES, default 5_000_000, idle cycles before an automatic resend of the last text (100 ms at 50 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2_500_000, maximum cycles BUSY may last before the transfer is abandoned.
REQ-004 CLK  in  1  clock; all logic on its rising edge.
REQ-005 RESET  in  1  reset, asynchronous, active-high.
REQ-006 req  in  2  per-requester level request; held until that requester's done pulse.
REQ-007 req0_line1, req0_line2, req1_line1, req1_line2  in  8*LINE_LENGTH each  requester text, MSB byte = leftmost character.
REQ-008 grant  out  2  one-hot owner of the current transfer; 0 during a refresh or when idle.
REQ-009 done  out  2  one-cycle pulse to the requester whose text finished.
REQ-010 timeout_err  out  1  one-cycle pulse when a transfer is abandoned.
REQ-011 send_text  out  1  one-cycle start strobe to the LCD text sender.
REQ-012 line1_out, line2_out  out  8*LINE_LENGTH each  registered text presented to the sender.
REQ-013 sending_done  in  1  one-cycle completion pulse from the sender.

Function
REQ-014 SHALL implement states IDLE, START, BUSY, DONE.
REQ-015 IDLE with any req bit set SHALL select a winner, load its line1/line2 into line1_out/line2_out, set grant one-hot, set text_valid, and enter START on the next edge.
REQ-016 Arbitration SHALL be round-robin: if both requests are set, the requester not served last wins; if only one is set, it wins.
REQ-017 START SHALL assert send_text for exactly one cycle, clear the timeout counter, and enter BUSY.
REQ-018 BUSY SHALL hold line1_out/line2_out/grant stable, increment the timeout counter, and enter DONE on sending_done.
REQ-019 sending_done SHALL be ignored in IDLE, START and DONE.
REQ-020 DONE SHALL pulse done[w] for one cycle for granted requester w (none if refresh), clear grant, update the round-robin pointer (grant only), clear the refresh counter, and return to IDLE.
REQ-021 If the timeout counter reaches TIMEOUT_CYCLES-1 in BUSY without sending_done, the block SHALL pulse timeout_err, clear grant, assert no done, leave the pointer unchanged, and return to IDLE.
REQ-022 The refresh counter SHALL increment only in IDLE, saturating at REFRESH_CYCLES-1.
REQ-023 IDLE with no req, text_valid=1 and the refresh counter at REFRESH_CYCLES-1 SHALL enter START with buffers unchanged and grant=0.
REQ-024 A request SHALL win over a due refresh in the same cycle.
REQ-025 Request changes after the grant SHALL NOT alter line1_out/line2_out until the next selection.
REQ-026 Minimum latency from req rise in IDLE to send_text SHALL be 2 cycles.
REQ-027 Back-to-back service: a req still high in the cycle after DONE SHALL be re-evaluated in IDLE.

Reset
REQ-028 On RESET the block SHALL enter IDLE and set to 0: grant, done, timeout_err, send_text, line1_out, line2_out, text_valid and both counters.
REQ-029 After RESET the round-robin pointer SHALL favour requester 0.
REQ-030 RESET asserted mid-transfer SHALL abandon it with no done or timeout_err pulse.

Structure
REQ-031 A shared package lcd_pkg SHALL hold LINE_LENGTH, FREQ (50_000_000) and the scheduler state enum.
REQ-032 The block SHALL contain no sub-module; the parent instantiates lcd_send_text and connects send_text/line1_out/line2_out/sending_done to it.
REQ-033 Counters SHALL be sized to $clog2 of their parameter.

Verification (REFRESH_CYCLES=100, TIMEOUT_CYCLES=50)
REQ-034 The bench SHALL cover: req=01, sending_done 20 cycles after send_text -> grant=01, send_text 2 cycles after req, done=01 for one cycle, line1_out = req0_line1.
REQ-035 The bench SHALL cover: req=11 held through three transfers -> grants in order 01, 10, 01.
REQ-036 The bench SHALL cover: no req for 100 idle cycles after a transfer -> send_text with grant=00, unchanged text, and no done pulse.
REQ-037 The bench SHALL cover: sending_done withheld -> timeout_err 50 cycles after entering BUSY, return to IDLE, and no done pulse.
REQ-038 The bench SHALL cover: req=10 on the same cycle the refresh falls due -> requester 1 served and no refresh strobe.
REQ-039 The bench SHALL cover: RESET pulsed mid-BUSY -> all outputs 0, and the next req=11 grants 01.
